// File: rtl/cordic_prerotate_if.sv
// Sample/phase bus between the upstream mixer and the CORDIC pre-rotation stage.
// The master drives the i_* side and reads back the o_* side.
interface cordic_prerotate_if #(
    parameter int IW = 13,
    parameter int WW = 16,
    parameter int PW = 20
);
    logic                 i_valid;
    logic signed [IW-1:0] i_xval;
    logic signed [IW-1:0] i_yval;
    logic        [PW-1:0] i_phase;
    logic                 o_valid;
    logic signed [WW-1:0] o_xval;
    logic signed [WW-1:0] o_yval;
    logic        [PW-1:0] o_phase;

    modport master (
        output i_valid, i_xval, i_yval, i_phase,
        input  o_valid, o_xval, o_yval, o_phase
    );

    modport slave (
        input  i_valid, i_xval, i_yval, i_phase,
        output o_valid, o_xval, o_yval, o_phase
    );
endinterface

// File: rtl/cordic_prerotate.sv
// Input conditioning ahead of the CORDIC core: widen I/Q, then rotate by the nearest
// quadrant so the residual phase lies in [-45deg, +45deg). Optional LFSR dither fill: CORDIC_PREROT_DITHER_EN.
module cordic_prerotate #(
    parameter int IW = 13,
    parameter int WW = 16,
    parameter int PW = 20
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ce,
    cordic_prerotate_if.slave   bus
);
    localparam int S = WW - IW - 1;

    if (WW < IW + 2) begin : g_width_check
        $error("cordic_prerotate: WW must be at least IW+2");
    end

    logic [S-1:0]         fill_bits_s;

    logic signed [WW-1:0] wx_d, wy_d;
    logic        [1:0]    q_d;
    logic        [PW-1:0] r_d;
    logic signed [WW-1:0] wx_q, wy_q;
    logic        [1:0]    q_q;
    logic        [PW-1:0] r_q;
    logic                 v1_q;

    logic signed [WW-1:0] x_d, y_d;
    logic signed [WW-1:0] x_q, y_q;
    logic        [PW-1:0] ph_q;
    logic                 v2_q;

`ifdef CORDIC_PREROT_DITHER_EN
    if (S > 16) begin : g_dither_check
        $error("cordic_prerotate: dither fill wider than the 16-bit LFSR");
    end

    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward the LSB
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // Dither state steps once per enabled cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lfsr_q <= 16'hACE1;
        end else if (i_ce) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign fill_bits_s = lfsr_q[S-1:0];
`else
    assign fill_bits_s = {S{1'b0}};
`endif

    // Stage 1: guard-bit widening plus nearest-quadrant split of the phase
    always_comb begin
        wx_d = {bus.i_xval[IW-1], bus.i_xval, fill_bits_s};
        wy_d = {bus.i_yval[IW-1], bus.i_yval, fill_bits_s};
        // Adding the 45deg bit rounds to the nearest quadrant; the 2-bit sum wraps mod 4
        q_d  = bus.i_phase[PW-1:PW-2] + {1'b0, bus.i_phase[PW-3]};
        r_d  = bus.i_phase - {q_d, {(PW-2){1'b0}}};
    end

    // Stage 1 registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wx_q <= {WW{1'b0}};
            wy_q <= {WW{1'b0}};
            q_q  <= 2'd0;
            r_q  <= {PW{1'b0}};
            v1_q <= 1'b0;
        end else if (i_ce) begin
            wx_q <= wx_d;
            wy_q <= wy_d;
            q_q  <= q_d;
            r_q  <= r_d;
            v1_q <= bus.i_valid;
        end
    end

    // Stage 2: quarter-turn rotation; one guard bit keeps every negation in range
    always_comb begin
        case (q_q)
            2'd0: begin
                x_d = wx_q;
                y_d = wy_q;
            end
            2'd1: begin
                x_d = -wy_q;
                y_d = wx_q;
            end
            2'd2: begin
                x_d = -wx_q;
                y_d = -wy_q;
            end
            2'd3: begin
                x_d = wy_q;
                y_d = -wx_q;
            end
            default: begin
                x_d = wx_q;
                y_d = wy_q;
            end
        endcase
    end

    // Stage 2 registers, driving the outputs directly
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            x_q  <= {WW{1'b0}};
            y_q  <= {WW{1'b0}};
            ph_q <= {PW{1'b0}};
            v2_q <= 1'b0;
        end else if (i_ce) begin
            x_q  <= x_d;
            y_q  <= y_d;
            ph_q <= r_q;
            v2_q <= v1_q;
        end
    end

    assign bus.o_valid = v2_q;
    assign bus.o_xval  = x_q;
    assign bus.o_yval  = y_q;
    assign bus.o_phase = ph_q;
endmodule

// File: tb/tb_cordic_prerotate.sv
// Directed and randomized checks of cordic_prerotate against an arithmetic reference model.
module tb_cordic_prerotate;
    localparam int IW = 13;
    localparam int WW = 16;
    localparam int PW = 20;
    localparam int S  = WW - IW - 1;

    typedef struct {
        logic          v;
        logic [WW-1:0] x;
        logic [WW-1:0] y;
        logic [PW-1:0] ph;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_reset;
    logic i_ce;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t stage_q[$];
    exp_t cur;
    exp_t zero_e;
    int   lfsr;

    cordic_prerotate_if #(.IW(IW), .WW(WW), .PW(PW)) bus ();

    cordic_prerotate #(.IW(IW), .WW(WW), .PW(PW)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    // Expected result from plain arithmetic: round phase to nearest quarter turn
    function automatic exp_t model(input logic v, input int x, input int y, input int ph, input int fill);
        exp_t e;
        int qd, wx, wy, ox, oy, r;
        qd = ((ph + (1 << (PW-3))) / (1 << (PW-2))) % 4;
        wx = x * (1 << S) + fill;
        wy = y * (1 << S) + fill;
        case (qd)
            0: begin ox = wx;  oy = wy;  end
            1: begin ox = -wy; oy = wx;  end
            2: begin ox = -wx; oy = -wy; end
            default: begin ox = wy; oy = -wx; end
        endcase
        r = ph - qd * (1 << (PW-2));
        if (r < 0) r = r + (1 << PW);
        e.v  = v;
        e.x  = ox[WW-1:0];
        e.y  = oy[WW-1:0];
        e.ph = r[PW-1:0];
        return e;
    endfunction

    task automatic check(input string tag);
        n_checks++;
        assert (bus.o_valid === cur.v) else begin
            n_fail++;
            $error("FAIL %s o_valid got=%0b want=%0b", tag, bus.o_valid, cur.v);
        end
        n_checks++;
        assert (bus.o_xval === cur.x) else begin
            n_fail++;
            $error("FAIL %s o_xval got=%0d want=%0d", tag, bus.o_xval, $signed(cur.x));
        end
        n_checks++;
        assert (bus.o_yval === cur.y) else begin
            n_fail++;
            $error("FAIL %s o_yval got=%0d want=%0d", tag, bus.o_yval, $signed(cur.y));
        end
        n_checks++;
        assert (bus.o_phase === cur.ph) else begin
            n_fail++;
            $error("FAIL %s o_phase got=%h want=%h", tag, bus.o_phase, cur.ph);
        end
    endtask

    // One clock: drive inputs, advance the model, compare outputs after the edge
    task automatic step(input string tag, input logic rst, input logic ce, input logic v,
                        input int x, input int y, input int ph);
        int fill;
        int fb;
        i_reset      = rst;
        i_ce         = ce;
        bus.i_valid  = v;
        bus.i_xval   = IW'(x);
        bus.i_yval   = IW'(y);
        bus.i_phase  = PW'(ph);
        @(posedge i_clk);
        #1;
        if (rst) begin
            stage_q.delete();
            stage_q.push_back(zero_e);
            cur  = zero_e;
            lfsr = 16'hACE1;
        end else if (ce) begin
`ifdef CORDIC_PREROT_DITHER_EN
            fill = lfsr % (1 << S);
`else
            fill = 0;
`endif
            fb   = (lfsr ^ (lfsr >> 2) ^ (lfsr >> 3) ^ (lfsr >> 5)) & 1;
            lfsr = (lfsr >> 1) | (fb << 15);
            stage_q.push_back(model(v, x, y, ph, fill));
            cur = stage_q.pop_front();
        end
        check(tag);
    endtask

    initial begin
        zero_e = '{v: 1'b0, x: '0, y: '0, ph: '0};
        cur    = zero_e;
        lfsr   = 16'hACE1;
        step("reset0", 1'b1, 1'b0, 1'b0, 0, 0, 0);
        step("reset1", 1'b1, 1'b1, 1'b1, 77, -5, 'h12345);
        for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b1, 1'b0, 0, 0, 0);

        step("ph0_in", 1'b0, 1'b1, 1'b1, 1000, 0, 'h00000);
        step("ph0_p1", 1'b0, 1'b1, 1'b0, 0, 0, 0);
        step("ph0_out", 1'b0, 1'b1, 1'b0, 0, 0, 0);
        step("ph0_after", 1'b0, 1'b1, 1'b0, 0, 0, 0);

        step("ph90_in", 1'b0, 1'b1, 1'b1, 1000, 0, 'h40000);
        step("ph67_in", 1'b0, 1'b1, 1'b1, 1000, 0, 'h30000);
        step("ph90_out", 1'b0, 1'b1, 1'b1, -4096, -4096, 'h80000);
        step("ph67_out", 1'b0, 1'b1, 1'b1, 300, -200, 'hE0000);
        step("neg_out", 1'b0, 1'b1, 1'b0, 0, 0, 0);
        step("ph315_out", 1'b0, 1'b1, 1'b0, 0, 0, 0);

        step("ce_a", 1'b0, 1'b1, 1'b1, 11, 22, 'h20000);
        step("ce_b", 1'b0, 1'b0, 1'b1, 99, 99, 'h60000);
        step("ce_c", 1'b0, 1'b1, 1'b1, -33, 44, 'hA0000);
        step("ce_d", 1'b0, 1'b0, 1'b0, 5, 5, 'h11111);
        step("ce_e", 1'b0, 1'b1, 1'b0, 0, 0, 0);
        step("ce_f", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step("ce_g", 1'b0, 1'b1, 1'b0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            step("rand", 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom),
                 int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096,
                 int'($urandom_range(0, (1 << PW) - 1)));
        end

        step("flight1", 1'b0, 1'b1, 1'b1, 123, 456, 'h50000);
        step("flight2", 1'b0, 1'b1, 1'b1, -789, 321, 'hC0000);
        step("mid_reset", 1'b1, 1'b1, 1'b1, 1, 1, 'h10000);
        step("post_rst1", 1'b0, 1'b1, 1'b1, 100, -100, 'h00000);
        step("post_rst2", 1'b0, 1'b1, 1'b0, 0, 0, 0);
        step("post_rst3", 1'b0, 1'b1, 1'b0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
